vlg_dist_disp: RTL and testbench

VLG_DIST_DISP -- requirements
Module: vlg_dist_disp

---
 rtl/vlg_dist_disp.sv | 97 +++++++++
 tb/tb_vlg_dist_disp.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/vlg_dist_disp.sv
// vlg_dist_disp: distance to BCD (double-dabble) plus 4-digit multiplexed 7-segment scan.
// Define LEADING_ZERO_BLANK_EN to blank zero digits above the most significant non-zero digit.
module vlg_dist_disp #(
  parameter int unsigned P_SCAN_US = 1000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_clk_en,
  input  logic [13:0] i_s_mm,
  output logic [15:0] o_bcd,
  output logic [3:0]  o_sel,
  output logic [7:0]  o_seg
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t      state_q, state_d;
  logic [3:0]  step_q, step_d;
  logic [15:0] acc_q, acc_d, adj;
  logic [13:0] bin_q, bin_d;
  logic [15:0] bcd_q, bcd_d;
  logic [15:0] scan_q, scan_d;
  logic [1:0]  dig_q, dig_d;
  logic [3:0]  sel_q, sel_d;
  logic [7:0]  seg_q, seg_d, dec;
  logic [3:0]  nib;
  logic        wrap, blank;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = SHIFT;
      SHIFT:   state_d = (step_q == 4'd13) ? DONE : SHIFT;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    adj = acc_q;
    for (int k = 0; k < 4; k++)
      adj[4*k +: 4] = (acc_q[4*k +: 4] >= 4'd5) ? acc_q[4*k +: 4] + 4'd3 : acc_q[4*k +: 4];
    step_d = (state_q == SHIFT) ? step_q + 4'd1 : 4'd0;
    {acc_d, bin_d} = (state_q == IDLE)  ? {16'h0, (i_s_mm > 14'd9999) ? 14'd9999 : i_s_mm} :
                     (state_q == SHIFT) ? {adj[14:0], bin_q, 1'b0} : {acc_q, bin_q};
    bcd_d  = (state_q == DONE) ? acc_q : bcd_q;
    wrap   = i_clk_en && (scan_q == 16'(P_SCAN_US - 1));
    scan_d = wrap ? 16'd0 : i_clk_en ? scan_q + 16'd1 : scan_q;
    dig_d  = wrap ? dig_q + 2'd1 : dig_q;
    // Select and segments both derive from the registered index/value, so they move together.
    sel_d  = ~(4'b0001 << dig_q);
    nib    = bcd_q[{dig_q, 2'b00} +: 4];
    case (nib)
      4'd0:    dec = 8'hC0;
      4'd1:    dec = 8'hF9;
      4'd2:    dec = 8'hA4;
      4'd3:    dec = 8'hB0;
      4'd4:    dec = 8'h99;
      4'd5:    dec = 8'h92;
      4'd6:    dec = 8'h82;
      4'd7:    dec = 8'hF8;
      4'd8:    dec = 8'h80;
      4'd9:    dec = 8'h90;
      default: dec = 8'hFF;
    endcase
`ifdef LEADING_ZERO_BLANK_EN
    blank = (dig_q == 2'd3) ? (bcd_q[15:12] == 4'd0) :
            (dig_q == 2'd2) ? (bcd_q[15:8] == 8'd0) :
            (dig_q == 2'd1) ? (bcd_q[15:4] == 12'd0) : 1'b0;
`else
    blank = 1'b0;
`endif
    seg_d = blank ? 8'hFF : dec;
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      step_q <= '0;
      acc_q  <= '0;
      bin_q  <= '0;
      bcd_q  <= '0;
      scan_q <= '0;
      dig_q  <= '0;
      sel_q  <= 4'b1110;
      seg_q  <= 8'hC0;
    end else begin
      step_q <= step_d;
      acc_q  <= acc_d;
      bin_q  <= bin_d;
      bcd_q  <= bcd_d;
      scan_q <= scan_d;
      dig_q  <= dig_d;
      sel_q  <= sel_d;
      seg_q  <= seg_d;
    end
  assign o_bcd = bcd_q;
  assign o_sel = sel_q;
  assign o_seg = seg_q;
endmodule

// File: tb/tb_vlg_dist_disp.sv
// tb_vlg_dist_disp: directed checks of conversion latency, clamping, digit scan and blanking.
module tb_vlg_dist_disp;
  logic        clk = 1'b0, rst_n = 1'b0, clk_en = 1'b0;
  logic [13:0] s_mm = 14'd0;
  logic [15:0] bcd;
  logic [3:0]  sel;
  logic [7:0]  seg;
  int vectors = 0, miscompares = 0;
  logic [3:0] sel_exp [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  vlg_dist_disp #(.P_SCAN_US(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_clk_en(clk_en), .i_s_mm(s_mm),
    .o_bcd(bcd), .o_sel(sel), .o_seg(seg)
  );
  always #5 clk = ~clk;
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    rst_n = 1'b0; clk_en = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask
  task automatic advance_digit;
    repeat (4) begin clk_en = 1'b1; step(1); clk_en = 1'b0; step(49); end
  endtask
  task automatic test_reset;
    s_mm = 14'd1234; rst_n = 1'b0;
    step(3);
    vectors++; if (bcd !== 16'h0000) begin miscompares++; $display("FAIL reset_bcd got %h want 0000", bcd); end
    vectors++; if (sel !== 4'b1110) begin miscompares++; $display("FAIL reset_sel got %b want 1110", sel); end
    vectors++; if (seg !== 8'hC0) begin miscompares++; $display("FAIL reset_seg got %h want c0", seg); end
    rst_n = 1'b1;
  endtask
  task automatic test_latency;
    s_mm = 14'd1234; do_reset();
    step(15);
    vectors++; if (bcd !== 16'h0000) begin miscompares++; $display("FAIL lat_clk15 got %h want 0000", bcd); end
    step(1);
    vectors++; if (bcd !== 16'h1234) begin miscompares++; $display("FAIL lat_clk16 got %h want 1234", bcd); end
    vectors++; if (seg !== 8'hC0) begin miscompares++; $display("FAIL lat_seg16 got %h want c0", seg); end
    step(1);
    vectors++; if (seg !== 8'h99) begin miscompares++; $display("FAIL lat_seg17 got %h want 99", seg); end
  endtask
  task automatic test_scan;
    logic [7:0] seg_exp [4] = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
    s_mm = 14'd1234; do_reset();
    step(17);
    for (int d = 0; d < 4; d++) begin
      vectors++; if (sel !== sel_exp[d]) begin miscompares++; $display("FAIL scan_sel%0d got %b want %b", d, sel, sel_exp[d]); end
      vectors++; if (seg !== seg_exp[d]) begin miscompares++; $display("FAIL scan_seg%0d got %h want %h", d, seg, seg_exp[d]); end
      for (int p = 0; p < 4; p++) begin
        clk_en = 1'b1; step(1); clk_en = 1'b0; step(49);
        if (p == 2) begin
          vectors++; if (sel !== sel_exp[d]) begin miscompares++; $display("FAIL scan_hold%0d got %b want %b", d, sel, sel_exp[d]); end
        end
      end
    end
    vectors++; if (sel !== 4'b1110) begin miscompares++; $display("FAIL scan_wrap got %b want 1110", sel); end
  endtask
  task automatic test_clamp;
    logic [13:0] vals [2] = '{14'd12000, 14'd16383};
    for (int v = 0; v < 2; v++) begin
      s_mm = vals[v]; do_reset();
      step(17);
      vectors++; if (bcd !== 16'h9999) begin miscompares++; $display("FAIL clamp_bcd%0d got %h want 9999", v, bcd); end
      for (int d = 0; d < 4; d++) begin
        vectors++; if (seg !== 8'h90) begin miscompares++; $display("FAIL clamp_seg%0d_%0d got %h want 90", v, d, seg); end
        advance_digit();
      end
    end
  endtask
  task automatic test_leading_zero;
    logic [13:0] vals [2]  = '{14'd7, 14'd0};
    logic [15:0] bcds [2]  = '{16'h0007, 16'h0000};
    logic [7:0]  units [2] = '{8'hF8, 8'hC0};
`ifdef LEADING_ZERO_BLANK_EN
    logic [7:0]  upper = 8'hFF;
`else
    logic [7:0]  upper = 8'hC0;
`endif
    for (int v = 0; v < 2; v++) begin
      s_mm = vals[v]; do_reset();
      step(17);
      vectors++; if (bcd !== bcds[v]) begin miscompares++; $display("FAIL lz_bcd%0d got %h want %h", v, bcd, bcds[v]); end
      vectors++; if (seg !== units[v]) begin miscompares++; $display("FAIL lz_units%0d got %h want %h", v, seg, units[v]); end
      for (int d = 1; d < 4; d++) begin
        advance_digit();
        vectors++; if (seg !== upper) begin miscompares++; $display("FAIL lz_dig%0d_%0d got %h want %h", v, d, seg, upper); end
      end
    end
  endtask
  task automatic test_mid_shift;
    s_mm = 14'd1234; do_reset();
    step(5);
    s_mm = 14'd5678;
    step(11);
    vectors++; if (bcd !== 16'h1234) begin miscompares++; $display("FAIL mid_first got %h want 1234", bcd); end
    step(15);
    vectors++; if (bcd !== 16'h1234) begin miscompares++; $display("FAIL mid_hold got %h want 1234", bcd); end
    step(1);
    vectors++; if (bcd !== 16'h5678) begin miscompares++; $display("FAIL mid_new got %h want 5678", bcd); end
  endtask
  task automatic test_reset_mid_shift;
    s_mm = 14'd5678; do_reset();
    advance_digit();
    step(16);
    vectors++; if (bcd !== 16'h5678) begin miscompares++; $display("FAIL rms_pre got %h want 5678", bcd); end
    step(8);
    rst_n = 1'b0;
    step(3);
    vectors++; if (bcd !== 16'h0000) begin miscompares++; $display("FAIL rms_bcd got %h want 0000", bcd); end
    vectors++; if (sel !== 4'b1110) begin miscompares++; $display("FAIL rms_sel got %b want 1110", sel); end
    vectors++; if (seg !== 8'hC0) begin miscompares++; $display("FAIL rms_seg got %h want c0", seg); end
    s_mm = 14'd4321; rst_n = 1'b1;
    step(15);
    vectors++; if (bcd !== 16'h0000) begin miscompares++; $display("FAIL rms_clk15 got %h want 0000", bcd); end
    step(1);
    vectors++; if (bcd !== 16'h4321) begin miscompares++; $display("FAIL rms_clk16 got %h want 4321", bcd); end
  endtask
  task automatic test_no_enable;
    s_mm = 14'd9; do_reset();
    advance_digit();
    vectors++; if (sel !== 4'b1101) begin miscompares++; $display("FAIL noen_start got %b want 1101", sel); end
    s_mm = 14'd42;
    step(300);
    vectors++; if (sel !== 4'b1101) begin miscompares++; $display("FAIL noen_sel got %b want 1101", sel); end
    vectors++; if (bcd !== 16'h0042) begin miscompares++; $display("FAIL noen_bcd got %h want 0042", bcd); end
    vectors++; if (seg !== 8'h99) begin miscompares++; $display("FAIL noen_seg got %h want 99", seg); end
  endtask
  initial begin
    test_reset();
    test_latency();
    test_scan();
    test_clamp();
    test_leading_zero();
    test_mid_shift();
    test_reset_mid_shift();
    test_no_enable();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
